// File: rtl/maxpool2x2_stage.sv
// 2x2 stride-2 max pooling over a raster-ordered 9-channel feature map.
// Horizontal pairs are reduced first; even-row results wait in a half-row line buffer for the odd row.
module maxpool2x2_stage #(
   parameter int int_bits  = 13,
   parameter int fm_width  = 16,
   parameter int fm_height = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic [8:0][int_bits-1:0]     in,
   output logic                         out_valid,
   output logic [8:0][int_bits-1:0]     out,
   output logic                         frame_done
);

   localparam int unsigned CW   = $clog2(fm_width);
   localparam int unsigned RW   = $clog2(fm_height);
   localparam int unsigned LB_N = fm_width / 2;
   localparam int unsigned IW   = (LB_N > 1) ? $clog2(LB_N) : 1;

   if (fm_width < 2 || (fm_width % 2) != 0 || fm_height < 2 || (fm_height % 2) != 0) begin : g_bad_geometry
      $error("maxpool2x2_stage: fm_width and fm_height must be even and at least 2");
   end

   logic [CW-1:0]               col_q, col_d;
   logic [RW-1:0]               row_q, row_d;
   logic [8:0][int_bits-1:0]    hreg_q, hreg_d;
   logic [8:0][int_bits-1:0]    lb_q [LB_N];
   logic [8:0][int_bits-1:0]    lb_d [LB_N];
   logic [8:0][int_bits-1:0]    out_q, out_d;
   logic                        out_valid_q, out_valid_d;
   logic                        frame_done_q, frame_done_d;
   logic [8:0][int_bits-1:0]    hmax;
   logic [IW-1:0]               idx;
   logic                        col_last, row_last;

   function automatic logic [int_bits-1:0] smax(input logic [int_bits-1:0] a,
                                                input logic [int_bits-1:0] b);
      return ($signed(a) > $signed(b)) ? a : b;
   endfunction

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      hreg_d       = hreg_q;
      lb_d         = lb_q;
      out_d        = out_q;
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      idx          = IW'(col_q >> 1);
      col_last     = (col_q == CW'(fm_width - 1));
      row_last     = (row_q == RW'(fm_height - 1));
      for (int unsigned k = 0; k < 9; k++) begin
         hmax[k] = smax(hreg_q[k], in[k]);
      end

      if (in_valid) begin
         if (!col_q[0]) begin
            hreg_d = in;
         end else if (!row_q[0]) begin
            lb_d[idx] = hmax;
         end else begin
            for (int unsigned k = 0; k < 9; k++) begin
               out_d[k] = smax(lb_q[idx][k], hmax[k]);
            end
            out_valid_d  = 1'b1;
            frame_done_d = col_last && row_last;
         end

         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_q        <= '0;
         row_q        <= '0;
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Data storage is written before it is read in every frame, so it carries no reset.
   always_ff @(posedge clk) begin
      hreg_q <= hreg_d;
      lb_q   <= lb_d;
   end

   assign out        = out_q;
   assign out_valid  = out_valid_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool2x2_stage.sv
// Directed bench for maxpool2x2_stage on a 4x4 map: ramps, signed windows, gaps, reset abort, back-to-back frames.
module tb_maxpool2x2_stage;

   localparam int IB = 13;
   localparam int W  = 4;
   localparam int H  = 4;

   logic                  clk = 1'b0;
   logic                  reset = 1'b0;
   logic                  in_valid = 1'b0;
   logic [8:0][IB-1:0]    in_px = '0;
   logic                  out_valid;
   logic [8:0][IB-1:0]    out_px;
   logic                  frame_done;

   int checks = 0;
   int errors = 0;
   int fr [16];
   int ex [4];
   logic [8:0][IB-1:0]    last_out = '0;

   maxpool2x2_stage #(.int_bits(IB), .fm_width(W), .fm_height(H)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in         (in_px),
      .out_valid  (out_valid),
      .out        (out_px),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic ev, input logic efd);
      chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, ev});
      chk({tag, " frame_done"}, {31'd0, frame_done}, {31'd0, efd});
      for (int k = 0; k < 9; k++) begin
         chk($sformatf("%s lane%0d", tag, k), {19'd0, out_px[k]}, {19'd0, last_out[k]});
      end
   endtask

   task automatic step(input logic v, input logic [8:0][IB-1:0] px, input logic ev,
                       input logic efd, input logic [8:0][IB-1:0] eo, input string tag);
      in_valid = v;
      in_px    = px;
      @(posedge clk);
      #1;
      if (ev) last_out = eo;
      chk_all(tag, ev, efd);
   endtask

   task automatic set_ramp(input int base);
      for (int i = 0; i < 16; i++) fr[i] = i + base;
      ex[0] = 5 + base;  ex[1] = 7 + base;  ex[2] = 13 + base;  ex[3] = 15 + base;
   endtask

   // Plays beats [0, nbeats) of fr; lane k carries fr + k*lane_step.
   task automatic run_frame(input bit gaps, input int lane_step, input int nbeats, input string tag);
      logic [8:0][IB-1:0] px, eo, junk;
      logic ev;
      int slot;
      for (int i = 0; i < nbeats; i++) begin
         slot = (i == 5) ? 0 : (i == 7) ? 1 : (i == 13) ? 2 : 3;
         ev   = (i == 5) || (i == 7) || (i == 13) || (i == 15);
         for (int k = 0; k < 9; k++) begin
            px[k]   = IB'(fr[i] + k * lane_step);
            eo[k]   = IB'(ex[slot] + k * lane_step);
            junk[k] = IB'($urandom);
         end
         step(1'b1, px, ev, (i == 15), eo, $sformatf("%s beat%0d", tag, i));
         if (gaps) step(1'b0, junk, 1'b0, 1'b0, '0, $sformatf("%s gap%0d", tag, i));
      end
   endtask

   initial begin
      #2 reset = 1'b1;
      #1;
      last_out = '0;
      chk_all("reset", 1'b0, 1'b0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;

      set_ramp(0);
      run_frame(1'b0, 10, 16, "ramp");

      fr = '{-3, -1, -4096, 4095,
             -8, -2, 0, 0,
             7, -7, 100, 100,
             -100, 6, -5, 100};
      ex = '{-1, 4095, 7, 100};
      run_frame(1'b0, 0, 16, "signed");

      set_ramp(0);
      run_frame(1'b1, 10, 16, "gaps");

      set_ramp(0);
      run_frame(1'b0, 10, 6, "abort");
      reset = 1'b1;
      #1;
      last_out = '0;
      chk_all("reset async", 1'b0, 1'b0);
      @(posedge clk); #1;
      chk_all("reset held", 1'b0, 1'b0);
      reset = 1'b0;
      run_frame(1'b0, 10, 16, "after_reset");

      set_ramp(0);
      run_frame(1'b0, 10, 16, "b2b0");
      set_ramp(100);
      run_frame(1'b0, 10, 16, "b2b1");

      step(1'b0, '0, 1'b0, 1'b0, '0, "idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
